// File: rtl/cpu_trace_buffer.sv
// ---------------------------------------------------------------------------
// cpu_trace_buffer
//
// Retirement-trace capture unit that snoops the commit stream of a CPU core.
// Retired instructions are stored in a DEPTH-entry FIFO, which either stops
// when full or overwrites its oldest entry. A self-loop on one PC marks the
// program as halted. Cycle and retirement counters run until halt. Entries
// are read out through a pop port with one cycle of latency.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   trace_valid    core retires an instruction this cycle
//   trace_pc       PC of the retiring instruction
//   trace_instr    instruction word
//   trace_result   ALU result
//   trace_wen      register-file write enable of the retirement
//   mode_wrap      0 = stop when full, 1 = overwrite the oldest entry
//   rd_en          pop request, ignored while empty
//   rd_valid       rd_* hold a popped entry this cycle
//   rd_pc/rd_instr/rd_result  popped entry fields
//   count          entries held
//   full / empty   count == DEPTH / count == 0
//   overflow       sticky: a capture hit a full buffer without a pop
//   halted         sticky: halt detected (cleared only by reset)
//   cycle_count    cycles since reset, frozen at halt, saturating
//   retired_count  retirements since reset, frozen at halt, saturating
// ---------------------------------------------------------------------------
module cpu_trace_buffer #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int HALT_REPEAT = 3,
  parameter int CAPTURE_ALL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_valid,
  input  logic [XLEN-1:0]          trace_pc,
  input  logic [31:0]              trace_instr,
  input  logic [XLEN-1:0]          trace_result,
  input  logic                     trace_wen,
  input  logic                     mode_wrap,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [XLEN-1:0]          rd_result,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         retired_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int OCC_W    = PTR_W + 1;
  localparam int REP_W    = $clog2(HALT_REPEAT + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             CAP_ALL  = (CAPTURE_ALL != 0);

  // Trace storage, one array per field
  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [31:0]     instr_mem  [DEPTH];
  logic [XLEN-1:0] result_mem [DEPTH];

  // FIFO state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;
  logic             mem_we_s;

  // Readout registers
  logic             rd_valid_q;
  logic [XLEN-1:0]  rd_pc_q;
  logic [31:0]      rd_instr_q;
  logic [XLEN-1:0]  rd_result_q;

  // Halt detection and counters
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [REP_W-1:0] rep_q,     rep_d;
  logic             halted_q,  halted_d;
  logic [CNT_W-1:0] cycle_q,   cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic full_s;
  logic empty_s;
  logic cap_req_s;
  logic rd_fire_s;

  assign full_s    = (count_q == OCC_FULL);
  assign empty_s   = (count_q == '0);
  assign cap_req_s = trace_valid & ~halted_q & (CAP_ALL | trace_wen);
  assign rd_fire_s = rd_en & ~empty_s;

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we_s   = 1'b0;

    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (cap_req_s) begin
      if (!full_s || rd_fire_s) begin
        // A simultaneous pop frees the slot the new entry lands in, so a
        // full buffer with a pop behaves like a plain write.
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (!rd_fire_s) begin
          count_d = count_q + OCC_ONE;
        end else begin
          count_d = count_q;
        end
      end else begin
        overflow_d = 1'b1;
        if (mode_wrap) begin
          // Full: wr_ptr == rd_ptr, so this write replaces the oldest entry
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
          mem_we_s = 1'b0;
        end
      end
    end else begin
      if (rd_fire_s) begin
        count_d = count_q - OCC_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // Halt detection and cycle/retire counter next-state
  always_comb begin
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    halted_d  = halted_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;

    if (!halted_q) begin
      if (cycle_q != '1) begin
        cycle_d = cycle_q + CNT_ONE;
      end else begin
        cycle_d = cycle_q;
      end

      if (trace_valid) begin
        if (retired_q != '1) begin
          retired_d = retired_q + CNT_ONE;
        end else begin
          retired_d = retired_q;
        end

        last_pc_d = trace_pc;
        if (trace_pc == last_pc_q) begin
          if (rep_q != REP_HALT) begin
            rep_d = rep_q + REP_ONE;
          end else begin
            rep_d = rep_q;
          end
        end else begin
          rep_d = REP_ONE;
        end

        // The retirement that completes the run is still captured, because
        // capture qualifies on the registered halt flag.
        if (rep_d == REP_HALT) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        rep_d = rep_q;
      end
    end else begin
      halted_d = 1'b1;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Trace storage write port; no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      pc_mem[wr_ptr_q]     <= trace_pc;
      instr_mem[wr_ptr_q]  <= trace_instr;
      result_mem[wr_ptr_q] <= trace_result;
    end
  end

  // Readout registers: present the oldest entry the cycle after a pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q  <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
      rd_result_q <= '0;
    end else begin
      rd_valid_q <= rd_fire_s;
      if (rd_fire_s) begin
        rd_pc_q     <= pc_mem[rd_ptr_q];
        rd_instr_q  <= instr_mem[rd_ptr_q];
        rd_result_q <= result_mem[rd_ptr_q];
      end
    end
  end

  // Halt detector and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_pc_q <= '0;
      rep_q     <= '0;
      halted_q  <= 1'b0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      rep_q     <= rep_d;
      halted_q  <= halted_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_pc         = rd_pc_q;
  assign rd_instr      = rd_instr_q;
  assign rd_result     = rd_result_q;
  assign count         = count_q;
  assign full          = full_s;
  assign empty         = empty_s;
  assign overflow      = overflow_q;
  assign halted        = halted_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_trace_buffer. Two instances (capture-all and
// regWrite-filtered) share one stimulus stream. A queue-based reference
// model predicts every pop and the status outputs; a negedge monitor
// compares what each instance presents against the model.
// ---------------------------------------------------------------------------
module tb_cpu_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;
  localparam int HR    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] res;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_pc = 32'h0;
  logic [31:0] trace_instr = 32'h0;
  logic [31:0] trace_result = 32'h0;
  logic        trace_wen = 1'b0;
  logic        mode_wrap = 1'b0;
  logic        rd_en = 1'b0;

  logic          rd_valid_w  [2];
  logic [31:0]   rd_pc_w     [2];
  logic [31:0]   rd_instr_w  [2];
  logic [31:0]   rd_result_w [2];
  logic [CW-1:0] count_w     [2];
  logic          full_w      [2];
  logic          empty_w     [2];
  logic          overflow_w  [2];
  logic          halted_w    [2];
  logic [31:0]   cyc_w       [2];
  logic [31:0]   ret_w       [2];

  cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W),
                     .HALT_REPEAT(HR), .CAPTURE_ALL(1)) u_dut_all (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_result(trace_result),
    .trace_wen(trace_wen), .mode_wrap(mode_wrap), .rd_en(rd_en),
    .rd_valid(rd_valid_w[0]), .rd_pc(rd_pc_w[0]), .rd_instr(rd_instr_w[0]),
    .rd_result(rd_result_w[0]), .count(count_w[0]), .full(full_w[0]),
    .empty(empty_w[0]), .overflow(overflow_w[0]), .halted(halted_w[0]),
    .cycle_count(cyc_w[0]), .retired_count(ret_w[0]));

  cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W),
                     .HALT_REPEAT(HR), .CAPTURE_ALL(0)) u_dut_flt (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_result(trace_result),
    .trace_wen(trace_wen), .mode_wrap(mode_wrap), .rd_en(rd_en),
    .rd_valid(rd_valid_w[1]), .rd_pc(rd_pc_w[1]), .rd_instr(rd_instr_w[1]),
    .rd_result(rd_result_w[1]), .count(count_w[1]), .full(full_w[1]),
    .empty(empty_w[1]), .overflow(overflow_w[1]), .halted(halted_w[1]),
    .cycle_count(cyc_w[1]), .retired_count(ret_w[1]));

  // Reference model state, one slot per instance
  ent_t        mq [2][$];   // buffer contents, oldest first
  ent_t        eq [2][$];   // scoreboard: popped entries awaiting rd_valid
  bit          m_ovf  [2];
  bit          m_halt [2];
  bit          m_rz   [2];  // readout fields must read zero (just reset)
  logic [31:0] m_cyc  [2];
  logic [31:0] m_ret  [2];
  logic [31:0] m_last [2];
  int          m_rep  [2];
  bit          mon_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge using the inputs present at that edge
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mq[k].delete();
        eq[k].delete();
        m_ovf[k] = 0; m_halt[k] = 0; m_rz[k] = 1;
        m_cyc[k] = 0; m_ret[k] = 0; m_last[k] = 0; m_rep[k] = 0;
      end else begin
        bit   cap;
        ent_t e;
        m_rz[k] = 0;
        cap = trace_valid && !m_halt[k] && (k == 0 || trace_wen);
        if (rd_en && mq[k].size() > 0) eq[k].push_back(mq[k].pop_front());
        if (cap) begin
          e.pc = trace_pc; e.instr = trace_instr; e.res = trace_result;
          if (mq[k].size() < DEPTH) mq[k].push_back(e);
          else begin
            m_ovf[k] = 1;
            if (mode_wrap) begin
              void'(mq[k].pop_front());
              mq[k].push_back(e);
            end
          end
        end
        if (!m_halt[k]) begin
          if (m_cyc[k] != 32'hFFFF_FFFF) m_cyc[k] = m_cyc[k] + 32'd1;
          if (trace_valid) begin
            if (m_ret[k] != 32'hFFFF_FFFF) m_ret[k] = m_ret[k] + 32'd1;
            m_rep[k]  = (trace_pc == m_last[k]) ? m_rep[k] + 1 : 1;
            m_last[k] = trace_pc;
            if (m_rep[k] >= HR) m_halt[k] = 1;
          end
        end
      end
    end
  endtask

  // Monitor: compare each instance against the model away from the edge
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("rd_valid", k, 64'(rd_valid_w[k]), 64'(eq[k].size() != 0));
        if (rd_valid_w[k] && eq[k].size() != 0) begin
          ent_t e;
          e = eq[k].pop_front();
          chk("rd_pc", k, 64'(rd_pc_w[k]), 64'(e.pc));
          chk("rd_instr", k, 64'(rd_instr_w[k]), 64'(e.instr));
          chk("rd_result", k, 64'(rd_result_w[k]), 64'(e.res));
        end else if (eq[k].size() != 0) begin
          void'(eq[k].pop_front());
        end
        if (m_rz[k]) begin
          chk("rd_pc_rst", k, 64'(rd_pc_w[k]), 64'd0);
          chk("rd_instr_rst", k, 64'(rd_instr_w[k]), 64'd0);
          chk("rd_result_rst", k, 64'(rd_result_w[k]), 64'd0);
        end
        chk("count", k, 64'(count_w[k]), 64'(mq[k].size()));
        chk("full", k, 64'(full_w[k]), 64'(mq[k].size() == DEPTH));
        chk("empty", k, 64'(empty_w[k]), 64'(mq[k].size() == 0));
        chk("overflow", k, 64'(overflow_w[k]), 64'(m_ovf[k]));
        chk("halted", k, 64'(halted_w[k]), 64'(m_halt[k]));
        chk("cycle_count", k, 64'(cyc_w[k]), 64'(m_cyc[k]));
        chk("retired_count", k, 64'(ret_w[k]), 64'(m_ret[k]));
      end
    end
  end

  // One clock of stimulus; model is stepped right after the edge
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                     input logic w, input logic wrap, input logic re);
    rst = r; trace_valid = v; trace_pc = pc; trace_wen = w;
    mode_wrap = wrap; rd_en = re;
    trace_instr = $urandom; trace_result = $urandom;
    @(posedge clk);
    model_edge();
    mon_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pops(input int n, input logic wrap);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, wrap, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, wrap, 1'b0);
  endtask

  initial begin
    logic [31:0] lpc;
    logic        wrap_r;

    // Stop-when-full
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
    chk("t1_count", 0, 64'(count_w[0]), 64'd4);
    chk("t1_full", 0, 64'(full_w[0]), 64'd1);
    chk("t1_ovf", 0, 64'(overflow_w[0]), 64'd1);
    pops(5, 1'b0);
    chk("t1_empty", 0, 64'(empty_w[0]), 64'd1);

    // Wrap mode
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b1, 1'b0);
    chk("t2_count", 0, 64'(count_w[0]), 64'd4);
    chk("t2_ovf", 0, 64'(overflow_w[0]), 64'd1);
    pops(5, 1'b1);

    // Full with simultaneous pop and capture
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h18, 1'b1, 1'b0, 1'b1);
    chk("t3_count", 0, 64'(count_w[0]), 64'd4);
    chk("t3_ovf", 0, 64'(overflow_w[0]), 64'd0);
    chk("t3_rd_pc", 0, 64'(rd_pc_w[0]), 64'h0);
    pops(5, 1'b0);

    // Halt on self-loop
    do_reset();
    cyc(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("t4_halted", 0, 64'(halted_w[0]), 64'd1);
    chk("t4_retired", 0, 64'(ret_w[0]), 64'd5);
    chk("t4_cycles", 0, 64'(cyc_w[0]), 64'd5);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("t4_cycles_frozen", 0, 64'(cyc_w[0]), 64'd5);
    pops(5, 1'b0);

    // regWrite filter
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 32'(i * 4), ((i % 2) == 0), 1'b0, 1'b0);
    chk("t5_count_flt", 1, 64'(count_w[1]), 64'd2);
    chk("t5_retired_flt", 1, 64'(ret_w[1]), 64'd4);
    chk("t5_count_all", 0, 64'(count_w[0]), 64'd4);
    pops(3, 1'b0);

    // Reset mid-operation, then pop while empty
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'(16 + i * 4), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("t6_count", 0, 64'(count_w[0]), 64'd0);
    chk("t6_ovf", 0, 64'(overflow_w[0]), 64'd0);
    chk("t6_halted", 0, 64'(halted_w[0]), 64'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t6_rd_valid", 0, 64'(rd_valid_w[0]), 64'd0);
    chk("t6_empty", 0, 64'(empty_w[0]), 64'd1);

    // Randomized traffic with occasional resets and self-loops
    do_reset();
    lpc = 32'h0;
    wrap_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      if ($urandom_range(0, 49) == 0) wrap_r = ~wrap_r;
      pc = ($urandom_range(0, 4) == 0) ? lpc : 32'($urandom_range(0, 15) * 4);
      lpc = pc;
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0), pc,
          1'($urandom_range(0, 1)), wrap_r, ($urandom_range(0, 9) < 4));
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("sb_drained", k, 64'(eq[k].size()), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
